// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared constants for the LED pattern sequencer: pattern-select codes,
//   FSM state encoding and bounce-direction encoding.
package led_seq_pkg;

    // Pattern select codes carried on the 2-bit mode input
    localparam logic [1:0] MODE_ROT_L  = 2'b00;
    localparam logic [1:0] MODE_ROT_R  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bounce travel direction: UP moves the lit LED towards the MSB
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage : led_seq_pkg

// File: rtl/led_pattern_sequencer_edge_detect.sv
// edge_detect
//   Detects transitions of a level that is synchronous to clk_in.
//   Ports:
//     clk_in   - system clock
//     resetn   - synchronous active-low reset
//     sig_in   - level to watch (registered elsewhere in the clk_in domain)
//     edge_out - combinational strobe, high in the cycle the change is seen
//   EDGE_SEL = 0 reports rising edges only, EDGE_SEL = 1 reports both edges.
module edge_detect #(
    parameter int EDGE_SEL = 0
) (
    input  logic clk_in,
    input  logic resetn,
    input  logic sig_in,
    output logic edge_out
);

    logic tick_q;

    // tick_q follows sig_in even during reset so a level that is already
    // high when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            tick_q <= sig_in;
        end else begin
            tick_q <= sig_in;
        end
    end

    assign edge_out = (EDGE_SEL != 0) ? (sig_in ^ tick_q) : (sig_in & ~tick_q);

endmodule : edge_detect

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Advances an LED pattern once per detected edge of the divided-clock
//   level tick_in. Four patterns: rotate-left, rotate-right, bounce and
//   binary up-count.
//   Ports:
//     clk_in     - system clock
//     resetn     - synchronous active-low reset
//     tick_in    - divided-clock level, synchronous to clk_in (not a clock)
//     enable     - 1 runs the pattern, 0 idles with LEDs dark
//     mode       - pattern select (see led_seq_pkg MODE_* codes)
//     led_out    - registered LED drive
//     step_pulse - one-cycle strobe on every pattern advance
//     wrap_pulse - one-cycle strobe when a pattern completes its period
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int LED_WIDTH = 4,
    parameter int EDGE_SEL  = 0
) (
    input  logic                 clk_in,
    input  logic                 resetn,
    input  logic                 tick_in,
    input  logic                 enable,
    input  logic [1:0]           mode,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 step_pulse,
    output logic                 wrap_pulse
);

    localparam logic [LED_WIDTH-1:0] LED_ONE = {{(LED_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LED_WIDTH-1:0] LED_MSB = {1'b1, {(LED_WIDTH-1){1'b0}}};

    state_e               state_q, state_d;
    logic [1:0]           mode_q;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 dir_q, dir_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;
    logic                 tick_edge;
    logic                 load;

    function automatic logic [LED_WIDTH-1:0] load_pattern(input logic [1:0] m);
        logic [LED_WIDTH-1:0] p;
        case (m)
            MODE_ROT_R: p = LED_MSB;
            MODE_COUNT: p = '0;
            default:    p = LED_ONE;   // rotate-left and bounce start at LSB
        endcase
        return p;
    endfunction

    edge_detect #(
        .EDGE_SEL (EDGE_SEL)
    ) u_edge_detect (
        .clk_in   (clk_in),
        .resetn   (resetn),
        .sig_in   (tick_in),
        .edge_out (tick_edge)
    );

    // Reload on entry to RUN or whenever the selected pattern changes;
    // an edge in the same cycle is dropped because load wins below.
    assign load = enable && ((state_q == ST_IDLE) || (mode_q != mode));

    // ---- state register ----
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- output / pattern next-value logic ----
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (!enable) begin
            led_d = '0;
        end else if (load) begin
            led_d = load_pattern(mode);
            dir_d = DIR_UP;
        end else if ((state_q == ST_RUN) && tick_edge) begin
            step_d = 1'b1;
            case (mode)
                MODE_ROT_L: begin
                    led_d  = {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
                    wrap_d = led_q[LED_WIDTH-1];
                end
                MODE_ROT_R: begin
                    led_d  = {led_q[0], led_q[LED_WIDTH-1:1]};
                    wrap_d = led_q[0];
                end
                MODE_BOUNCE: begin
                    // Turn around at the ends without dwelling there
                    if (dir_q == DIR_UP) begin
                        if (led_q[LED_WIDTH-1]) begin
                            led_d = led_q >> 1;
                            dir_d = DIR_DN;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = led_q << 1;
                            dir_d = DIR_UP;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                    // A period ends whenever the lit LED lands on the LSB
                    wrap_d = led_d[0];
                end
                default: begin
                    led_d  = led_q + LED_ONE;
                    wrap_d = &led_q;
                end
            endcase
        end
    end

    // ---- pattern, direction, mode history and strobe registers ----
    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            led_q  <= '0;
            dir_q  <= DIR_UP;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            mode_q <= mode;
        end else begin
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
            mode_q <= mode;
        end
    end

    assign led_out    = led_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;

endmodule : led_pattern_sequencer

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Consumes the slow divided clock produced by the board clock divider and advances an LED pattern once per divided-clock edge. Both blocks run in the same `clk_in` domain: `tick_in` is a registered level, not a clock, and is never used as one. The block sits between the divider and the board LED pins and provides four selectable patterns, an enable, and step/wrap strobes for status logic.

## Interface
- `LED_WIDTH`, default 4: number of LEDs driven; must be ≥ 2.
- `EDGE_SEL`, default 0: 0 steps on rising edges of `tick_in` only; 1 steps on both edges.
- `clk_in`  input  1  system clock (125 MHz PL clock).
- `resetn`  input  1  reset; one clock, synchronous, active-low.
- `tick_in`  input  1  divided-clock level from the clock divider, synchronous to `clk_in`.
- `enable`  input  1  level; 1 = run the pattern, 0 = idle with LEDs dark.
- `mode`  input  2  pattern select: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary up-count.
- `led_out`  output  LED_WIDTH  registered LED drive.
- `step_pulse`  output  1  one-cycle strobe on every pattern advance.
- `wrap_pulse`  output  1  one-cycle strobe when a pattern completes a full period.

## Operation
- Edge detect:
  - `tick_q` holds `tick_in` from the previous cycle.
  - With `EDGE_SEL`=0, `edge = tick_in & ~tick_q`.
  - With `EDGE_SEL`=1, `edge = tick_in ^ tick_q`.
- Reset behaviour: during reset, `tick_q` loads `tick_in`, not 0. A high `tick_in` at reset release therefore causes no spurious step.
- FSM states:
  - IDLE: `led_out`=0.
  - RUN: the pattern advances.
  - IDLE→RUN when `enable`=1.
  - RUN→IDLE when `enable`=0.
- Load on entering RUN, or on any `mode` change while in RUN (`mode_q` ≠ `mode`):
  - mode 00 and 10: `led_out`=0…01; bounce direction = up.
  - mode 01: `led_out`=10…0.
  - mode 11: `led_out`=0.
- Per-edge update in RUN:
  - 00: rotate left. MSB wraps to LSB; `wrap_pulse` on that step.
  - 01: rotate right. LSB wraps to MSB; `wrap_pulse` on that step.
  - 10: one-hot shift in the current direction. At MSB the direction flips to down and the next value is MSB−1; at LSB it flips to up. There is no dwell at the ends, so the period is 2·(LED_WIDTH−1) steps. `wrap_pulse` fires on the step that lands on LSB.
  - 11: increment modulo 2^LED_WIDTH. `wrap_pulse` fires on the all-ones→0 step.
- `step_pulse` is asserted exactly on cycles where a per-edge update is applied. It is never asserted on a load.
- Priority, highest first:
  1. reset
  2. `enable`=0
  3. load (entry or mode change)
  4. edge step

  An edge coinciding with a load is dropped.
- IDLE ignores edges; `led_out` stays 0 and both strobes stay 0.

## Timing
- Reset values: `led_out`=0, `step_pulse`=0, `wrap_pulse`=0, state=IDLE, `mode_q`=`mode`, bounce direction=up.
- `tick_in` first sampled high at posedge k (previously low): `led_out`, `step_pulse` and `wrap_pulse` all update at posedge k. The strobes drop at k+1 unless another edge occurs.
- `enable` sampled 1 at posedge k: state=RUN and the initial pattern is visible after posedge k.
- `enable` sampled 0 at posedge k: `led_out`=0 after posedge k.
- `mode` change sampled at posedge k: the reload pattern is visible after posedge k.
- Reset asserted mid-pattern: all outputs are 0 after the first sampled-low `resetn` edge.
- Minimum spacing between edges: 1 cycle. Every detected edge is applied; nothing is queued.

## Structure
- Shared package `led_seq_pkg` contains:
  - mode constants `MODE_ROT_L`, `MODE_ROT_R`, `MODE_BOUNCE`, `MODE_COUNT`;
  - state encoding `ST_IDLE`, `ST_RUN`;
  - bounce direction constants `DIR_UP`, `DIR_DN`.
- One sub-module, `edge_detect`:
  - parameter `EDGE_SEL`;
  - ports `clk_in`, `resetn`, `sig_in`, `edge_out`;
  - contains `tick_q` and its reset-load behaviour.
- The top level holds the FSM, `mode_q`, the pattern register, the direction flag and the strobes.

## Test plan
All scenarios use `LED_WIDTH`=4 and `EDGE_SEL`=0 unless stated.
1. Reset with `tick_in`=1, release, `enable`=1, `mode`=00 → `led_out`=0001 with no step at release; rising edges give 0010, 0100, 1000, 0001, with `wrap_pulse` on the 1000→0001 step only.
2. Mode 10, 7 edges → 0010, 0100, 1000, 0100, 0010, 0001, 0010; `wrap_pulse` on the 6th edge only.
3. Mode 11, 16 edges → counts 1…15 then 0; `wrap_pulse` on the 16th edge; `step_pulse` high on each of the 16 cycles.
4. `mode` changed 00→01 in the same cycle as a `tick_in` rising edge → `led_out`=1000, `step_pulse`=0, edge dropped; next edge gives 0100.
5. `enable` dropped mid-pattern, then edges applied → `led_out`=0 after one cycle and no strobes; re-enable reloads the initial pattern.
6. `EDGE_SEL`=1, mode 00, one full `tick_in` period → two steps, 0001→0010→0100; `resetn` low mid-run → all outputs 0 after one clock.
